// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the fifo write-port arbiter and its round-robin selector.
package fifo_wr_arbiter_pkg;

    localparam int MAX_N_REQ = 8;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((32'sd1 <<< result) < value) begin
            result = result + 32'sd1;
        end
        return result;
    endfunction

    localparam int IDX_W = clog2(MAX_N_REQ);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    function automatic logic [MAX_N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        return {{(MAX_N_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester strictly after last, with wrap-around.
module rr_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IW    = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    last_i,
    output logic [IW-1:0]    pick_o,
    output logic             valid_o
);

    // Scan offsets 1..N_REQ from last; the first hit wins, later hits are masked by valid_o.
    always_comb begin
        pick_o  = last_i;
        valid_o = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            pick_o  = (req_i[IW'((int'(last_i) + k) % N_REQ)] & ~valid_o)
                      ? IW'((int'(last_i) + k) % N_REQ) : pick_o;
            valid_o = valid_o | req_i[IW'((int'(last_i) + k) % N_REQ)];
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port between N_REQ producers in bursts
// of up to MAX_BURST words, with FULL backpressure applied in the same cycle.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter  int N_REQ     = 4,
    parameter  int DATA_W    = 32,
    parameter  int MAX_BURST = 4,
    localparam int OW        = clog2(N_REQ),
    localparam int CW        = clog2(MAX_BURST + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   data,
    input  logic                      FULL,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          ack,
    output logic                      fifo_en,
    output logic                      fifo_wr,
    output logic [DATA_W-1:0]         fifo_dataIn,
    output logic                      busy,
    output logic [OW-1:0]             owner,
    output logic [CW-1:0]             beat_cnt
);

    state_t            state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [CW-1:0]     beat_cnt_q, beat_cnt_d;
    logic              fifo_en_q;
    logic [OW-1:0]     pick_s;
    logic              pick_valid_s;
    logic              beat_s;
    logic              last_beat_s;

    // owner_q doubles as the last-owner pointer: it only changes on a new grant.
    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req_i   (req),
        .last_i  (owner_q),
        .pick_o  (pick_s),
        .valid_o (pick_valid_s)
    );

    assign beat_s      = gnt_q[owner_q] & req[owner_q] & ~FULL & fifo_en_q;
    assign last_beat_s = beat_s & ((beat_cnt_q + CW'(1)) == CW'(MAX_BURST));

    // Next-state: grant from IDLE, count beats in BURST, leave on burst limit or req drop.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_valid_s) begin
                    state_d    = BURST;
                    gnt_d      = N_REQ'(onehot(IDX_W'(pick_s)));
                    owner_d    = pick_s;
                    beat_cnt_d = {CW{1'b0}};
                end else begin
                    gnt_d = {N_REQ{1'b0}};
                end
            end
            BURST: begin
                if (beat_s) begin
                    beat_cnt_d = beat_cnt_q + CW'(1);
                end else begin
                    beat_cnt_d = beat_cnt_q;
                end
                if (last_beat_s || !req[owner_q]) begin
                    state_d = IDLE;
                    gnt_d   = {N_REQ{1'b0}};
                end else begin
                    state_d = BURST;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = {N_REQ{1'b0}};
            end
        endcase
    end

    // Beat accept and write data mux; data is presented for the whole burst, even while stalled.
    always_comb begin
        ack          = {N_REQ{1'b0}};
        ack[owner_q] = beat_s;
        if (state_q == BURST) begin
            fifo_dataIn = data[int'(owner_q)*DATA_W +: DATA_W];
        end else begin
            fifo_dataIn = {DATA_W{1'b0}};
        end
    end

    // State registers; reset points last owner at N_REQ-1 so producer 0 is scanned first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= {N_REQ{1'b0}};
            owner_q    <= OW'(N_REQ - 1);
            beat_cnt_q <= {CW{1'b0}};
            fifo_en_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
            fifo_en_q  <= 1'b1;
        end
    end

    assign gnt      = gnt_q;
    assign owner    = owner_q;
    assign beat_cnt = beat_cnt_q;
    assign fifo_en  = fifo_en_q;
    assign fifo_wr  = beat_s;
    assign busy     = (state_q == BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus randomized producers and FULL,
// all checked cycle by cycle against a behavioural arbiter model.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int MB = 4;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*DW-1:0] data;
    logic            FULL;
    logic [N-1:0]    gnt;
    logic [N-1:0]    ack;
    logic            fifo_en;
    logic            fifo_wr;
    logic [DW-1:0]   fifo_dataIn;
    logic            busy;
    logic [1:0]      owner;
    logic [2:0]      beat_cnt;

    fifo_wr_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req(req), .data(data), .FULL(FULL),
        .gnt(gnt), .ack(ack), .fifo_en(fifo_en), .fifo_wr(fifo_wr),
        .fifo_dataIn(fifo_dataIn), .busy(busy), .owner(owner), .beat_cnt(beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: arbiter state as plain integers, producers as word counters.
    bit m_busy, m_en;
    int m_owner, m_cnt;
    int remain [N];
    int seq    [N];
    int full_pct, drop_pct, reload_pct, full_hold;
    int wr_seen;
    bit prev_busy;
    int dut_grants [$];
    int burst_len  [$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] word(input int i);
        logic [31:0] s;
        s = seq[i];
        return {i[7:0], s[23:0]};
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_en    = 1'b0;
        m_owner = N - 1;
        m_cnt   = 0;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (remain[i] > 0 && int'($urandom_range(99)) < drop_pct)
                remain[i] = 0;
            else if (remain[i] == 0 && int'($urandom_range(99)) < reload_pct)
                remain[i] = int'($urandom_range(10, 1));
            req[i] = (remain[i] > 0);
            data[i*DW +: DW] = word(i);
        end
        if (full_hold > 0) begin
            FULL = 1'b1;
            full_hold--;
        end else begin
            FULL = (int'($urandom_range(99)) < full_pct);
        end
    endtask

    // One clock: drive at negedge, compare 1 time unit later, advance the model, wait next negedge.
    task automatic step();
        bit beat;
        drive();
        #1;
        beat = m_busy && req[m_owner] && !FULL && m_en;
        check_eq("gnt",      gnt,         m_busy ? (64'd1 << m_owner) : 64'd0);
        check_eq("owner",    owner,       m_owner);
        check_eq("busy",     busy,        m_busy);
        check_eq("beat_cnt", beat_cnt,    m_cnt);
        check_eq("fifo_en",  fifo_en,     m_en);
        check_eq("fifo_wr",  fifo_wr,     beat);
        check_eq("ack",      ack,         beat ? (64'd1 << m_owner) : 64'd0);
        check_eq("dataIn",   fifo_dataIn, m_busy ? word(m_owner) : 32'd0);
        check_eq("wr_while_full", fifo_wr & FULL, 1'b0);
        check_eq("gnt_onehot0", $onehot0(gnt), 1'b1);
        if (fifo_wr) wr_seen++;
        if (busy && !prev_busy) dut_grants.push_back(int'(owner));
        if (!busy && prev_busy) burst_len.push_back(int'(beat_cnt));
        prev_busy = busy;
        if (beat) begin
            seq[m_owner]++;
            remain[m_owner]--;
        end
        if (!m_busy) begin
            for (int k = 1; k <= N; k++) begin
                if (req[(m_owner + k) % N]) begin
                    m_owner = (m_owner + k) % N;
                    m_busy  = 1'b1;
                    m_cnt   = 0;
                    break;
                end
            end
        end else begin
            if (beat) m_cnt++;
            if ((beat && m_cnt == MB) || !req[m_owner]) m_busy = 1'b0;
        end
        m_en = 1'b1;
        @(negedge clk);
    endtask

    int exp_order [5] = '{0, 1, 2, 3, 0};
    int exp_len   [3] = '{4, 4, 2};
    int w0;

    initial begin
        rst = 1'b0; req = '0; data = '0; FULL = 1'b0;
        full_pct = 0; drop_pct = 0; reload_pct = 0; full_hold = 0; wr_seen = 0; prev_busy = 1'b0;
        for (int i = 0; i < N; i++) begin
            remain[i] = 0;
            seq[i]    = 0;
        end
        model_reset();
        #1 rst = 1'b1;
        #1;
        check_eq("rst_gnt", gnt, 4'b0000);
        check_eq("rst_fifo_en", fifo_en, 1'b0);
        check_eq("rst_beat_cnt", beat_cnt, 3'd0);
        check_eq("rst_owner", owner, 2'd3);
        check_eq("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // All producers requesting from reset: grant order 0,1,2,3,0.
        for (int i = 0; i < N; i++) remain[i] = 100;
        repeat (25) step();
        check_eq("grant_count", dut_grants.size() >= 5, 1'b1);
        for (int i = 0; i < 5; i++)
            if (i < dut_grants.size()) check_eq("grant_order", dut_grants[i], exp_order[i]);
        for (int i = 0; i < N; i++) remain[i] = 0;
        repeat (3) step();

        // Single producer 2 with 10 words: bursts of 4, 4, 2.
        dut_grants.delete();
        burst_len.delete();
        w0 = wr_seen;
        remain[2] = 10;
        repeat (22) step();
        check_eq("p2_words", wr_seen - w0, 10);
        check_eq("p2_bursts", burst_len.size(), 3);
        for (int i = 0; i < 3; i++)
            if (i < burst_len.size()) check_eq("p2_burst_len", burst_len[i], exp_len[i]);
        for (int i = 0; i < dut_grants.size(); i++) check_eq("p2_owner", dut_grants[i], 2);

        // FULL stall of 5 cycles after 2 beats from producer 3.
        remain[3] = 4;
        for (int k = 0; k < 20 && !(m_busy && m_cnt == 2); k++) step();
        check_eq("reach_stall", beat_cnt, 3'd2);
        w0 = wr_seen;
        full_hold = 5;
        repeat (5) step();
        check_eq("stall_no_wr", wr_seen - w0, 0);
        check_eq("stall_gnt", gnt, 4'b1000);
        repeat (6) step();
        check_eq("stall_resume", wr_seen - w0, 2);

        // Reset during beat 2 of a producer-3 burst; producer 0 must win afterwards.
        remain[3] = 4;
        for (int k = 0; k < 20 && !(m_busy && m_cnt == 1); k++) step();
        check_eq("reach_beat2", beat_cnt, 3'd1);
        remain[0] = 5;
        req[0] = 1'b1;
        rst = 1'b1;
        #1;
        check_eq("midrst_gnt", gnt, 4'b0000);
        check_eq("midrst_fifo_en", fifo_en, 1'b0);
        check_eq("midrst_beat_cnt", beat_cnt, 3'd0);
        check_eq("midrst_owner", owner, 2'd3);
        check_eq("midrst_fifo_wr", fifo_wr, 1'b0);
        model_reset();
        prev_busy = busy;
        @(negedge clk);
        rst = 1'b0;
        step();
        check_eq("post_rst_owner", owner, 2'd0);
        check_eq("post_rst_gnt", gnt, 4'b0001);

        // Randomized producers with random backpressure and abandoned requests.
        full_pct = 25; drop_pct = 3; reload_pct = 30;
        repeat (3000) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
